rv32i_fetch_queue: RTL and testbench

Consumer end of the instruction prefetch interface. It sits between the prefetch stage and decode. It drives the prefetch stage's advance and PC-redirect inputs, and captures the registered instruction/PC pair the prefetch stage returns one cycle later. It buffers those pairs in a small FIFO, presents them to decode with a valid/ready handshake, and flushes on control-flow redirects from execute.

---
 rtl/rv32i_fetch_queue_if.sv | 33 +++
 rtl/rv32i_fetch_queue.sv | 110 +++++++++++
 tb/tb_rv32i_fetch_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_queue_if.sv
// Prefetch-side and decode-side signals of the instruction fetch queue.
// The master modport is the queue's view; the slave modport is its environment.
interface rv32i_fetch_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_i;
  logic [XLEN-1:0] fetch_instruction_i;
  logic            fetch_advance_o;
  logic            fetch_pc_write_o;
  logic [XLEN-1:0] fetch_pc_o;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            valid_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] instruction_o;
  logic            ready_i;
  logic [CW-1:0]   count_o;

  modport master (
    input  fetch_pc_i, fetch_instruction_i, redirect_i, redirect_pc_i, ready_i,
    output fetch_advance_o, fetch_pc_write_o, fetch_pc_o,
    output valid_o, pc_o, instruction_o, count_o
  );

  modport slave (
    output fetch_pc_i, fetch_instruction_i, redirect_i, redirect_pc_i, ready_i,
    input  fetch_advance_o, fetch_pc_write_o, fetch_pc_o,
    input  valid_o, pc_o, instruction_o, count_o
  );
endinterface

// File: rtl/rv32i_fetch_queue.sv
// Fetch queue between prefetch and decode: credit-based advance, FIFO buffering,
// and a full flush with PC redirect when execute changes control flow.
module rv32i_fetch_queue #(
  parameter int unsigned    XLEN        = 32,
  parameter int unsigned    DEPTH       = 4,
  parameter logic [XLEN-1:0] VTABLE_ADDR = '0
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  rv32i_fetch_queue_if.master  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {BOOT, RUN} state_e;

  state_e          state, next_state;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   credit;
  logic            inflight;
  logic            advance, pc_write;
  logic [XLEN-1:0] target;
  logic            push, pop, flush, valid;

  logic [XLEN-1:0] store_pc    [DEPTH];
  logic [XLEN-1:0] store_instr [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!reset_ni) state <= BOOT;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      BOOT: next_state = RUN;
      RUN:  next_state = RUN;
    endcase
  end

  // Outstanding fetches count against capacity so a returning word always has a slot.
  assign credit = count + CW'(inflight);

  always_comb begin
    advance  = 1'b0;
    pc_write = 1'b0;
    target   = bus.redirect_pc_i;
    if (!reset_ni) begin
      target = VTABLE_ADDR;
    end else begin
      unique case (state)
        BOOT: begin
          advance  = 1'b1;
          pc_write = 1'b1;
          target   = bus.redirect_i ? bus.redirect_pc_i : VTABLE_ADDR;
        end
        RUN: begin
          if (bus.redirect_i) begin
            advance  = 1'b1;
            pc_write = 1'b1;
          end else begin
            advance = credit < CW'(DEPTH);
          end
        end
      endcase
    end
  end

  assign valid = reset_ni && (count != '0);
  assign flush = (state == RUN) && bus.redirect_i;
  assign push  = (state == RUN) && inflight && !bus.redirect_i;
  assign pop   = valid && bus.ready_i && !flush;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= advance;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      store_pc[wr_ptr]    <= bus.fetch_pc_i;
      store_instr[wr_ptr] <= bus.fetch_instruction_i;
    end
  end

  assign bus.fetch_advance_o  = advance;
  assign bus.fetch_pc_write_o = pc_write;
  assign bus.fetch_pc_o       = target;
  assign bus.valid_o          = valid;
  assign bus.count_o          = reset_ni ? count : '0;
  assign bus.pc_o             = store_pc[rd_ptr];
  assign bus.instruction_o    = store_instr[rd_ptr];
endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Bench for rv32i_fetch_queue: directed vector table followed by random traffic,
// both checked against a queue-based reference model and a small prefetch model.
module tb_rv32i_fetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NVEC  = 30;
  localparam logic [31:0] VT    = 32'h0000_0000;

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_count;
    logic        e_adv;
    logic        e_pcw;
    logic [31:0] e_fpc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pf_pc;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  vec_t        vecs [NVEC];
  logic [63:0] mq [$];
  bit          m_boot = 1'b1;
  bit          m_inflight = 1'b0;

  rv32i_fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

  rv32i_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .VTABLE_ADDR(VT)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hBEEF, ~pc[15:0]};
  endfunction

  // Prefetch stage: registered PC, returned one cycle after the advance.
  always_ff @(posedge clk) begin
    if (bus.fetch_advance_o)
      pf_pc <= bus.fetch_pc_write_o ? bus.fetch_pc_o : pf_pc + 32'd4;
  end
  assign bus.fetch_pc_i          = pf_pc;
  assign bus.fetch_instruction_i = mem_word(pf_pc);

  function automatic vec_t mk(input logic r, input logic d, input logic [31:0] rp, input logic y,
                              input logic ev, input logic [31:0] ep, input logic [2:0] ec,
                              input logic ea, input logic ew, input logic [31:0] ef);
    vec_t t;
    t.rst_n = r; t.redir = d; t.rpc = rp; t.rdy = y;
    t.e_valid = ev; t.e_pc = ep; t.e_count = ec; t.e_adv = ea; t.e_pcw = ew; t.e_fpc = ef;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic d, input logic [31:0] rp, input logic y,
                                input bit use_tab, input vec_t tv);
    logic        e_valid, e_adv, e_pcw;
    logic [31:0] e_fpc;
    int          e_count;
    rst_n             = r;
    bus.redirect_i    = d;
    bus.redirect_pc_i = rp;
    bus.ready_i       = y;
    #4;
    if (!r) begin
      e_valid = 1'b0; e_count = 0; e_adv = 1'b0; e_pcw = 1'b0; e_fpc = VT;
    end else begin
      e_valid = (mq.size() != 0);
      e_count = mq.size();
      if (m_boot) begin
        e_adv = 1'b1; e_pcw = 1'b1; e_fpc = d ? rp : VT;
      end else if (d) begin
        e_adv = 1'b1; e_pcw = 1'b1; e_fpc = rp;
      end else begin
        e_adv = (mq.size() + int'(m_inflight)) < DEPTH;
        e_pcw = 1'b0; e_fpc = rp;
      end
    end
    check_output("model_valid", 32'(bus.valid_o), 32'(e_valid));
    check_output("model_count", 32'(bus.count_o), 32'(e_count));
    check_output("model_advance", 32'(bus.fetch_advance_o), 32'(e_adv));
    check_output("model_pc_write", 32'(bus.fetch_pc_write_o), 32'(e_pcw));
    check_output("model_fetch_pc", bus.fetch_pc_o, e_fpc);
    if (e_valid) begin
      check_output("model_head_pc", bus.pc_o, mq[0][63:32]);
      check_output("model_head_instr", bus.instruction_o, mq[0][31:0]);
    end
    if (use_tab) begin
      check_output("vec_valid", 32'(bus.valid_o), 32'(tv.e_valid));
      check_output("vec_count", 32'(bus.count_o), 32'(tv.e_count));
      check_output("vec_advance", 32'(bus.fetch_advance_o), 32'(tv.e_adv));
      check_output("vec_pc_write", 32'(bus.fetch_pc_write_o), 32'(tv.e_pcw));
      check_output("vec_fetch_pc", bus.fetch_pc_o, tv.e_fpc);
      if (tv.e_valid) begin
        check_output("vec_head_pc", bus.pc_o, tv.e_pc);
        check_output("vec_head_instr", bus.instruction_o, mem_word(tv.e_pc));
      end
    end
    // Reference update for the coming edge.
    if (!r) begin
      mq.delete();
      m_inflight = 1'b0;
      m_boot     = 1'b1;
    end else if (m_boot) begin
      m_boot     = 1'b0;
      m_inflight = 1'b1;
    end else if (d) begin
      mq.delete();
      m_inflight = 1'b1;
    end else begin
      if (y && mq.size() != 0) void'(mq.pop_front());
      if (m_inflight) mq.push_back({pf_pc, bus.fetch_instruction_i});
      m_inflight = e_adv;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vec_t dummy;
    int   ready_pct;
    logic r, d, y;
    logic [31:0] rp;

    for (int i = 0; i < 5; i++) vecs[i] = mk(0,0,32'h100,1, 0,32'h0,0,0,0,32'h0);
    vecs[5]  = mk(1,0,32'h100,1, 0,32'h00,0,1,1,32'h000);
    vecs[6]  = mk(1,0,32'h100,1, 0,32'h00,0,1,0,32'h100);
    vecs[7]  = mk(1,0,32'h100,1, 1,32'h00,1,1,0,32'h100);
    vecs[8]  = mk(1,0,32'h100,1, 1,32'h04,1,1,0,32'h100);
    vecs[9]  = mk(1,0,32'h100,1, 1,32'h08,1,1,0,32'h100);
    vecs[10] = mk(1,0,32'h100,0, 1,32'h0C,1,1,0,32'h100);
    vecs[11] = mk(1,0,32'h100,0, 1,32'h0C,2,1,0,32'h100);
    vecs[12] = mk(1,0,32'h100,0, 1,32'h0C,3,0,0,32'h100);
    vecs[13] = mk(1,0,32'h100,0, 1,32'h0C,4,0,0,32'h100);
    vecs[14] = mk(1,0,32'h100,0, 1,32'h0C,4,0,0,32'h100);
    vecs[15] = mk(1,0,32'h100,1, 1,32'h0C,4,0,0,32'h100);
    vecs[16] = mk(1,0,32'h100,1, 1,32'h10,3,1,0,32'h100);
    vecs[17] = mk(1,0,32'h100,1, 1,32'h14,2,1,0,32'h100);
    vecs[18] = mk(1,0,32'h100,0, 1,32'h18,2,1,0,32'h100);
    vecs[19] = mk(1,1,32'h040,0, 1,32'h18,3,1,1,32'h040);
    vecs[20] = mk(1,0,32'h100,0, 0,32'h00,0,1,0,32'h100);
    vecs[21] = mk(1,0,32'h100,0, 1,32'h40,1,1,0,32'h100);
    vecs[22] = mk(1,0,32'h100,0, 1,32'h40,2,1,0,32'h100);
    vecs[23] = mk(1,0,32'h100,1, 1,32'h40,3,0,0,32'h100);
    vecs[24] = mk(1,0,32'h100,1, 1,32'h44,3,1,0,32'h100);
    vecs[25] = mk(1,0,32'h100,1, 1,32'h48,2,1,0,32'h100);
    vecs[26] = mk(0,0,32'h100,0, 0,32'h00,0,0,0,32'h000);
    vecs[27] = mk(1,0,32'h100,1, 0,32'h00,0,1,1,32'h000);
    vecs[28] = mk(1,0,32'h100,1, 0,32'h00,0,1,0,32'h100);
    vecs[29] = mk(1,0,32'h100,1, 1,32'h00,1,1,0,32'h100);

    rst_n = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h100;
    bus.ready_i = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < int'(NVEC); i++)
      apply_stimulus(vecs[i].rst_n, vecs[i].redir, vecs[i].rpc, vecs[i].rdy, 1'b1, vecs[i]);

    dummy = vecs[0];
    ready_pct = 80;
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) ready_pct = int'($urandom_range(10, 100));
      r  = ($urandom_range(0, 79) != 0);
      d  = ($urandom_range(0, 15) == 0);
      rp = 32'($urandom_range(0, 255)) << 2;
      y  = (int'($urandom_range(0, 99)) < ready_pct);
      apply_stimulus(r, d, rp, y, 1'b0, dummy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
